// File: rtl/wu_decode_if.sv
// rtl/wu_decode_if.sv - option line stream in, decoded descriptor beat stream out
interface wu_decode_if #(
    parameter int OPT_PER_INST = 3,
    parameter int OPT_TYPE_W   = 4,
    parameter int OPT_VALUE_W  = 16
);
    localparam int NTYPES = 1 << OPT_TYPE_W;

    logic                              wum__wud__valid;
    logic [1:0]                        wum__wud__icntl;
    logic [1:0]                        wum__wud__dcntl;
    logic [OPT_PER_INST*OPT_TYPE_W-1:0]  wum__wud__option_type;
    logic [OPT_PER_INST*OPT_VALUE_W-1:0] wum__wud__option_value;

    logic                              wud__odc__valid;
    logic                              odc__wud__ready;
    logic [1:0]                        wud__odc__cntl;
    logic [NTYPES-1:0]                 wud__odc__opt_bitmap;
    logic [NTYPES*OPT_VALUE_W-1:0]     wud__odc__opt_values;

    // Upstream line source plus downstream consumer
    modport master (
        output wum__wud__valid, wum__wud__icntl, wum__wud__dcntl,
               wum__wud__option_type, wum__wud__option_value,
        output odc__wud__ready,
        input  wud__odc__valid, wud__odc__cntl, wud__odc__opt_bitmap, wud__odc__opt_values
    );

    // Decode stage
    modport slave (
        input  wum__wud__valid, wum__wud__icntl, wum__wud__dcntl,
               wum__wud__option_type, wum__wud__option_value,
        input  odc__wud__ready,
        output wud__odc__valid, wud__odc__cntl, wud__odc__opt_bitmap, wud__odc__opt_values
    );
endinterface

// File: rtl/wu_decode.sv
// rtl/wu_decode.sv - WU option decode into per-descriptor table, 4-entry beat FIFO; optional checker macro WU_DECODE_ERR_CHECK_EN
module wu_decode #(
    parameter int OPT_PER_INST = 3,
    parameter int OPT_TYPE_W   = 4,
    parameter int OPT_VALUE_W  = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic      clk,
    input  logic      reset_poweron,
    wu_decode_if.slave bus,
    output logic      xxx__wuf__stall,
    output logic      wud__mcntl__idle,
    output logic      wud__mcntl__err
);
    localparam int NTYPES = 1 << OPT_TYPE_W;
    localparam int TBL_W  = NTYPES * OPT_VALUE_W;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {IDLE, DESC} state_t;

    typedef struct packed {
        logic [1:0]        cntl;
        logic [NTYPES-1:0] bitmap;
        logic [TBL_W-1:0]  values;
    } beat_t;

    state_t                state;
    logic [NTYPES-1:0]     bitmap_q;
    logic [NTYPES-1:0]     line_bitmap;
    logic [TBL_W-1:0]      table_q;
    logic [TBL_W-1:0]      line_table;
    logic [OPT_TYPE_W-1:0] slot_type;
    logic                  inst_first;
    logic                  inst_open;

    beat_t                 fifo_mem [FIFO_DEPTH];
    beat_t                 head;
    beat_t                 push_beat;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic in_valid, desc_start, desc_end, inst_start, inst_end;
    logic full, pop, push_ok;

    assign in_valid   = bus.wum__wud__valid;
    assign desc_start = in_valid & bus.wum__wud__dcntl[1];
    assign desc_end   = in_valid & bus.wum__wud__dcntl[0];
    assign inst_start = in_valid & bus.wum__wud__icntl[1];
    assign inst_end   = in_valid & bus.wum__wud__icntl[0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Merge this line's option slots into the table; higher slots overwrite lower ones
    always_comb begin
        line_bitmap = desc_start ? '0 : bitmap_q;
        line_table  = table_q;
        slot_type   = '0;
        for (int s = 0; s < OPT_PER_INST; s++) begin
            slot_type = bus.wum__wud__option_type[s*OPT_TYPE_W +: OPT_TYPE_W];
            if (in_valid && slot_type != '0) begin
                line_table[int'(slot_type)*OPT_VALUE_W +: OPT_VALUE_W] =
                    bus.wum__wud__option_value[s*OPT_VALUE_W +: OPT_VALUE_W];
                line_bitmap[slot_type] = 1'b1;
            end
        end
    end

    // The emitted beat includes the end line's own options
    assign push_beat = '{cntl:   {inst_first | inst_start, inst_end},
                         bitmap: line_bitmap,
                         values: line_table};

    // Descriptor FSM with option table and instruction tracking
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            state      <= IDLE;
            bitmap_q   <= '0;
            table_q    <= '0;
            inst_first <= 1'b0;
            inst_open  <= 1'b0;
        end else if (in_valid) begin
            bitmap_q <= line_bitmap;
            table_q  <= line_table;
            case (state)
                IDLE:    if (desc_start && !desc_end) state <= DESC;
                DESC:    if (desc_end) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (desc_end)
                inst_first <= 1'b0;
            else if (inst_start)
                inst_first <= 1'b1;
            if (inst_end)
                inst_open <= 1'b0;
            else if (inst_start)
                inst_open <= 1'b1;
        end
    end

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop     = (count != '0) && bus.odc__wud__ready;
    // When full, a same-cycle pop frees the slot the write pointer aims at
    assign push_ok = desc_end && (!full || pop);

    // Output FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_mem[i] <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= push_beat;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    assign head                     = fifo_mem[rd_ptr];
    assign bus.wud__odc__valid      = (count != '0);
    assign bus.wud__odc__cntl       = head.cntl;
    assign bus.wud__odc__opt_bitmap = head.bitmap;
    assign bus.wud__odc__opt_values = head.values;

    // Two lines may still be in flight from wu_memory after stall rises
    assign xxx__wuf__stall  = (count >= CNT_W'(FIFO_DEPTH - 2));
    assign wud__mcntl__idle = (count == '0) && (state == IDLE) && !inst_open;

`ifdef WU_DECODE_ERR_CHECK_EN
    logic err_q;
    logic overflow;
    logic proto_err;

    assign overflow  = desc_end && full && !pop;
    assign proto_err = in_valid && ((desc_start && state == DESC) ||
                                    (!bus.wum__wud__dcntl[1] && state == IDLE) ||
                                    (inst_start && inst_open));

    // Sticky protocol error flag
    always_ff @(posedge clk) begin
        if (reset_poweron)
            err_q <= 1'b0;
        else if (overflow || proto_err)
            err_q <= 1'b1;
    end

    assign wud__mcntl__err = err_q;
`else
    assign wud__mcntl__err = 1'b0;
`endif

endmodule

// File: tb/tb_wu_decode.sv
// tb/tb_wu_decode.sv - directed and random checks of wu_decode against a queue-based reference model
module tb_wu_decode;
    localparam int OPI   = 3;
    localparam int TW    = 4;
    localparam int VW    = 16;
    localparam int NT    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_poweron;
    logic stall, idle, err;

    wu_decode_if #(.OPT_PER_INST(OPI), .OPT_TYPE_W(TW), .OPT_VALUE_W(VW)) bus ();

    wu_decode #(.OPT_PER_INST(OPI), .OPT_TYPE_W(TW), .OPT_VALUE_W(VW), .FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_poweron    (reset_poweron),
        .bus              (bus),
        .xxx__wuf__stall  (stall),
        .wud__mcntl__idle (idle),
        .wud__mcntl__err  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       cntl;
        logic [NT-1:0]    bitmap;
        logic [NT*VW-1:0] values;
    } exp_beat_t;

    exp_beat_t     exp_q[$];
    logic [VW-1:0] m_table [NT];
    logic [NT-1:0] m_bitmap;
    bit            m_in_desc, m_inst_first, m_inst_open, m_err;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [NT*VW-1:0] obs, input logic [NT*VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NT*VW-1:0] masked(input logic [NT*VW-1:0] vals, input logic [NT-1:0] bm);
        logic [NT*VW-1:0] r = vals;
        for (int t = 0; t < NT; t++)
            if (!bm[t]) r[t*VW +: VW] = '0;
        return r;
    endfunction

    function automatic logic [NT*VW-1:0] model_values();
        logic [NT*VW-1:0] r;
        for (int t = 0; t < NT; t++)
            r[t*VW +: VW] = m_table[t];
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_bitmap = '0;
        for (int t = 0; t < NT; t++) m_table[t] = '0;
        m_in_desc = 0; m_inst_first = 0; m_inst_open = 0; m_err = 0;
    endtask

    task automatic model_line(input bit v, input logic [1:0] ic, input logic [1:0] dc,
                              input logic [OPI*TW-1:0] ty, input logic [OPI*VW-1:0] va, input bit rdy);
        bit        pop_now, was_full;
        exp_beat_t b;
        int        t;
        was_full = (exp_q.size() == DEPTH);
        pop_now  = rdy && (exp_q.size() > 0);
        if (pop_now) void'(exp_q.pop_front());
        if (v) begin
`ifdef WU_DECODE_ERR_CHECK_EN
            if ((dc[1] && m_in_desc) || (!dc[1] && !m_in_desc) || (ic[1] && m_inst_open))
                m_err = 1;
`endif
            if (dc[1]) m_bitmap = '0;
            for (int s = 0; s < OPI; s++) begin
                t = int'(ty[s*TW +: TW]);
                if (t != 0) begin
                    m_table[t]  = va[s*VW +: VW];
                    m_bitmap[t] = 1'b1;
                end
            end
            if (ic[1]) m_inst_first = 1;
            if (dc[0]) begin
                b.cntl   = {m_inst_first, ic[0]};
                b.bitmap = m_bitmap;
                b.values = model_values();
                m_inst_first = 0;
                if (!was_full || pop_now)
                    exp_q.push_back(b);
`ifdef WU_DECODE_ERR_CHECK_EN
                else
                    m_err = 1;
`endif
            end
            if (ic[1]) m_inst_open = 1;
            if (ic[0]) m_inst_open = 0;
            if (dc[0]) m_in_desc = 0;
            else if (dc[1]) m_in_desc = 1;
        end
    endtask

    task automatic check_outputs();
        check("valid", bus.wud__odc__valid, exp_q.size() != 0);
        check("stall", stall, exp_q.size() >= DEPTH - 2);
        check("idle", idle, (exp_q.size() == 0) && !m_in_desc && !m_inst_open);
        check("err", err, m_err);
        if (exp_q.size() != 0) begin
            check("head_cntl", bus.wud__odc__cntl, exp_q[0].cntl);
            check("head_bitmap", bus.wud__odc__opt_bitmap, exp_q[0].bitmap);
            check("head_values", masked(bus.wud__odc__opt_values, exp_q[0].bitmap),
                  masked(exp_q[0].values, exp_q[0].bitmap));
        end
    endtask

    // Drive at a falling edge, update the model at the rising edge, check at the next falling edge
    task automatic step(input bit v, input logic [1:0] ic, input logic [1:0] dc,
                        input logic [OPI*TW-1:0] ty, input logic [OPI*VW-1:0] va, input bit rdy);
        bus.wum__wud__valid        = v;
        bus.wum__wud__icntl        = ic;
        bus.wum__wud__dcntl        = dc;
        bus.wum__wud__option_type  = ty;
        bus.wum__wud__option_value = va;
        bus.odc__wud__ready        = rdy;
        @(posedge clk);
        model_line(v, ic, dc, ty, va, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic single(input int t, input logic [VW-1:0] val, input bit rdy);
        step(1'b1, 2'b11, 2'b11, {8'h00, 4'(t)}, {32'h0, val}, rdy);
    endtask

    task automatic idle_step(input bit rdy);
        step(1'b0, 2'b00, 2'b00, '0, '0, rdy);
    endtask

    task automatic do_reset();
        reset_poweron       = 1'b1;
        bus.wum__wud__valid = 1'b0;
        bus.odc__wud__ready = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        reset_poweron = 1'b0;
        check_outputs();
    endtask

    logic [1:0]        r_ic, r_dc;
    logic [OPI*TW-1:0] r_ty;
    logic [OPI*VW-1:0] r_va;
    int                nd, nl;
    bit                exp_err_ovf;

    initial begin
        reset_poweron              = 1'b1;
        bus.wum__wud__valid        = 1'b0;
        bus.wum__wud__icntl        = '0;
        bus.wum__wud__dcntl        = '0;
        bus.wum__wud__option_type  = '0;
        bus.wum__wud__option_value = '0;
        bus.odc__wud__ready        = 1'b0;
`ifdef WU_DECODE_ERR_CHECK_EN
        exp_err_ovf = 1'b1;
`else
        exp_err_ovf = 1'b0;
`endif

        // Reset values
        do_reset();
        check("rst_valid", bus.wud__odc__valid, 1'b0);
        check("rst_idle", idle, 1'b1);
        check("rst_stall", stall, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_cntl", bus.wud__odc__cntl, 2'b00);
        check("rst_bitmap", bus.wud__odc__opt_bitmap, 16'h0000);
        check("rst_values", bus.wud__odc__opt_values, '0);

        // Single-line descriptor
        step(1'b1, 2'b11, 2'b11, {4'd0, 4'd2, 4'd1}, {16'($urandom), 16'h0020, 16'h0010}, 1'b1);
        check("single_valid", bus.wud__odc__valid, 1'b1);
        check("single_cntl", bus.wud__odc__cntl, 2'b11);
        check("single_bitmap", bus.wud__odc__opt_bitmap, 16'h0006);
        check("single_t1", bus.wud__odc__opt_values[1*VW +: VW], 16'h0010);
        check("single_t2", bus.wud__odc__opt_values[2*VW +: VW], 16'h0020);
        idle_step(1'b1);
        check("single_drained", bus.wud__odc__valid, 1'b0);

        // Three-line descriptor, then a one-line descriptor, in one instruction
        step(1'b1, 2'b10, 2'b10, {4'd0, 4'd0, 4'd5}, {32'h0, 16'h000A}, 1'b1);
        check("desc_busy_idle", idle, 1'b0);
        step(1'b1, 2'b00, 2'b00, {4'd0, 4'd3, 4'd3}, {16'h0, 16'h0032, 16'h0031}, 1'b1);
        step(1'b1, 2'b00, 2'b01, {4'd0, 4'd0, 4'd5}, {32'h0, 16'h000B}, 1'b1);
        check("multi1_cntl", bus.wud__odc__cntl, 2'b10);
        check("multi1_bitmap", bus.wud__odc__opt_bitmap, 16'h0028);
        check("multi1_t5", bus.wud__odc__opt_values[5*VW +: VW], 16'h000B);
        check("multi1_t3_dup", bus.wud__odc__opt_values[3*VW +: VW], 16'h0032);
        step(1'b1, 2'b01, 2'b11, {4'd0, 4'd0, 4'd7}, {32'h0, 16'h0077}, 1'b1);
        check("multi2_cntl", bus.wud__odc__cntl, 2'b01);
        check("multi2_bitmap", bus.wud__odc__opt_bitmap, 16'h0080);
        idle_step(1'b1);

        // Fill with ready low, watch stall
        for (int k = 0; k < 4; k++) begin
            single(k + 1, 16'h0100 + 16'(k), 1'b0);
            if (k == 0) check("stall_at1", stall, 1'b0);
            if (k == 1) check("stall_at2", stall, 1'b1);
        end
        check("full_err", err, 1'b0);
        check("full_head", bus.wud__odc__opt_bitmap, 16'h0002);

        // Push and pop together while full
        single(9, 16'h0099, 1'b1);
        check("pushpop_stall", stall, 1'b1);
        check("pushpop_err", err, 1'b0);
        for (int k = 0; k < 4; k++) begin
            idle_step(1'b1);
            if (k == 2) check("pushpop_last", bus.wud__odc__opt_bitmap, 16'h0200);
        end
        check("pushpop_empty", bus.wud__odc__valid, 1'b0);

        // Overflow drops the beat
        for (int k = 0; k < 4; k++) single(10 + k, 16'h0A00 + 16'(k), 1'b0);
        single(14, 16'h00EE, 1'b0);
        check("ovf_err", err, exp_err_ovf);
        for (int k = 0; k < 4; k++) begin
            idle_step(1'b1);
            if (k == 2) check("ovf_last_kept", bus.wud__odc__opt_bitmap, 16'h2000);
        end
        check("ovf_dropped", bus.wud__odc__valid, 1'b0);

        // Reset mid-descriptor with two FIFO entries
        do_reset();
        single(1, 16'h0001, 1'b0);
        single(2, 16'h0002, 1'b0);
        step(1'b1, 2'b10, 2'b10, {4'd0, 4'd0, 4'd4}, {32'h0, 16'h0044}, 1'b0);
        check("pre_rst_stall", stall, 1'b1);
        do_reset();
        check("mid_rst_valid", bus.wud__odc__valid, 1'b0);
        check("mid_rst_stall", stall, 1'b0);
        check("mid_rst_idle", idle, 1'b1);
        check("mid_rst_err", err, 1'b0);

        // Random well-formed instructions
        for (int i = 0; i < 60; i++) begin
            nd = $urandom_range(1, 3);
            for (int d = 0; d < nd; d++) begin
                nl = $urandom_range(1, 3);
                for (int l = 0; l < nl; l++) begin
                    r_ic = {d == 0 && l == 0, d == nd - 1 && l == nl - 1};
                    r_dc = {l == 0, l == nl - 1};
                    for (int s = 0; s < OPI; s++) begin
                        r_ty[s*TW +: TW] = 4'($urandom_range(0, 7) * 2 + (l & 1));
                        r_va[s*VW +: VW] = 16'($urandom);
                    end
                    step(1'b1, r_ic, r_dc, r_ty, r_va, $urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 3) == 0) idle_step(1'($urandom_range(0, 1)));
                end
            end
        end
        repeat (6) idle_step(1'b1);
        check("final_empty", bus.wud__odc__valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wu_decode.md
# wu_decode

Work-unit decode stage of the manager, directly downstream of `wu_memory`. It consumes the per-line option stream (`wum__wud__*`), accumulates option type/value pairs into a per-descriptor option table, and emits one decoded descriptor beat per descriptor through a 4-entry output FIFO to the downstream consumer (the operation/DMA controller). It drives `xxx__wuf__stall` back to `wu_fetch`, so lines still in flight from `wu_memory` always fit in the FIFO.

## Interface
Parameters:
- `OPT_PER_INST`, 3: option slots per WU memory line.
- `OPT_TYPE_W`, 4: option type width; the table holds 2^OPT_TYPE_W = 16 entries.
- `OPT_VALUE_W`, 16: option value width.
- `FIFO_DEPTH`, 4: output FIFO entries.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`, input, 1: clock.
- `reset_poweron`, input, 1: synchronous active-high reset.
- `wum__wud__valid`, input, 1: line valid. There is no back-pressure on this port.
- `wum__wud__icntl`, input, 2: instruction delineator.
- `wum__wud__dcntl`, input, 2: descriptor delineator.
- `wum__wud__option_type`, input, OPT_PER_INST*OPT_TYPE_W: slot 0 is in the LSBs.
- `wum__wud__option_value`, input, OPT_PER_INST*OPT_VALUE_W: slot 0 is in the LSBs.
- `xxx__wuf__stall`, output, 1: tells `wu_fetch` to stop issuing reads.
- `wud__odc__valid`, output, 1: FIFO head valid.
- `odc__wud__ready`, input, 1: consumer accepts the head.
- `wud__odc__cntl`, output, 2: instruction position of the descriptor.
- `wud__odc__opt_bitmap`, output, 16: bit t set means option type t is present.
- `wud__odc__opt_values`, output, 16*OPT_VALUE_W: table entry t sits at bits [t*OPT_VALUE_W +: OPT_VALUE_W].
- `wud__mcntl__idle`, output, 1: block is idle.
- `wud__mcntl__err`, output, 1: sticky protocol error (see Configuration).

## Operation
- Control encoding, used for `icntl`, `dcntl` and `odc cntl`:
  - 2'b11: start and end.
  - 2'b10: start.
  - 2'b00: middle.
  - 2'b01: end.
- Descriptor FSM states: IDLE and DESC.
  - IDLE to DESC: valid line with a `dcntl` start bit and no end bit.
  - DESC to IDLE: valid line with a `dcntl` end bit.
  - A 2'b11 line stays in IDLE and emits a beat.
- Descriptor start line: clears the bitmap. Table values are not cleared; the bitmap qualifies them.
- Every valid line, per slot s in order 0 to OPT_PER_INST-1:
  - Type 0 is NOP and is ignored.
  - Any other type t writes `table[t] = value` and sets bitmap bit t.
  - If two slots of one line carry the same type, the higher slot wins. Across lines, the later line wins.
- Instruction tracking: an `inst_first` flag is set by an `icntl` start bit and cleared on each emit.
- Descriptor end line: pushes {cntl, bitmap, table} into the FIFO, including that line's own options.
  - cntl bit1 = `inst_first`.
  - cntl bit0 = the line's `icntl` end bit.
- Stall: `xxx__wuf__stall = (count >= FIFO_DEPTH-2)`, decoded from the registered count. Up to 2 lines may still arrive after stall rises.
- Idle: `wud__mcntl__idle = (count==0) && state==IDLE && !inst_open`.
  - `inst_open` sets on an `icntl` start bit and clears on an `icntl` end bit.

## Timing
- Reset values: all outputs 0 except `wud__mcntl__idle`, which is 1. Count 0, state IDLE, bitmap 0, `inst_first` 0, `inst_open` 0, error 0.
- Reset mid-descriptor: the partial descriptor and all FIFO contents are discarded on the reset edge.
- Latency: a descriptor end line at edge N is written at edge N. `wud__odc__valid` is high in cycle N+1 when the FIFO was empty (registered head, fall-through).
- Output handshake:
  - A pop occurs on `valid && ready`.
  - The head data is stable while valid is high and ready is low.
- Simultaneous push and pop:
  - When full, the push is accepted and count stays the same.
  - When empty, the push lands and valid stays high next cycle.
- Push when full with no pop is an overflow. The beat is dropped and count stays at FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH. Count has width clog2(FIFO_DEPTH)+1.

## Configuration
- `WU_DECODE_ERR_CHECK_EN` defined: `wud__mcntl__err` is set, sticky until reset, by any of the following:
  - overflow;
  - a `dcntl` start bit while in DESC;
  - `dcntl` middle or end while in IDLE;
  - an `icntl` start bit while `inst_open`.
- The offending line is otherwise processed normally, apart from the overflow drop.
- `WU_DECODE_ERR_CHECK_EN` undefined:
  - `wud__mcntl__err` is tied to 0 and the checker logic is absent.
  - Behaviour on malformed sequences is unspecified.
  - Overflow still drops the beat.

## Test plan
- Single-line descriptor: `icntl` = `dcntl` = 2'b11, types {1,2,0}, values {0x10,0x20,x}, ready = 1.
  - Next cycle: valid, cntl 2'b11, bitmap 0x0006, table[1] = 0x10, table[2] = 0x20.
- Three-line descriptor within a two-descriptor instruction, with type 5 written on lines 1 and 3 (values 0xA, 0xB).
  - First beat: cntl 2'b10, table[5] = 0xB.
  - Second beat: cntl 2'b01, and its bitmap excludes types present only in the first.
- Ready held 0 while 4 single-line descriptors arrive:
  - stall rises the cycle after count reaches 2;
  - count reaches 4, with no overflow and err 0;
  - then ready = 1 drains the beats in order, one per cycle.
- Full FIFO, with a push and a pop in the same cycle: count stays 4, no error, and the new beat appears last.
- Full FIFO with ready 0 plus one more descriptor end line: the beat is dropped, and `wud__mcntl__err` = 1 when `WU_DECODE_ERR_CHECK_EN` is defined, 0 when it is not.
- Reset asserted in DESC with 2 FIFO entries: on the next cycle valid = 0, stall = 0, idle = 1.
